full_subtractor: RTL and testbench
==================================

# full_subtractor

Registered full subtractor with an optional ripple-borrow chain. It computes a − b − bin on unsigned operands and produces the difference and a borrow-out. Outputs are registered one clock after the inputs are sampled. With the default WIDTH of 1 it is the classic single-bit full subtractor cell. Wider instances act as a small arithmetic stage inside datapaths that chain borrows between slices.

## Interface
Parameters:
- WIDTH, default 1: operand and difference width in bits; legal range 1–64.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high; sampled on the rising clk edge.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in; weight 1 (LSB).
- in_valid  input  1  qualifies a, b and bin in the current cycle.
- d  output  WIDTH  registered difference.
- bout  output  1  registered borrow-out from the MSB.
- out_valid  output  1  high for exactly one cycle per accepted input.

## Operation
- Bit cell i, with borrow chain c[0] = bin:
  - d[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i])
  - bout = c[WIDTH].
- Arithmetic contract, unsigned:
  - {bout, d} = ({1'b0, a} − {1'b0, b} − bin) mod 2^(WIDTH+1).
  - bout = 1 exactly when a < b + bin.
- The borrow chain is purely combinational within a cycle. No carry-lookahead is required, but the implementation must meet the same results bit-exactly.
- Single-bit truth table (a b bin → d bout):
  - 000→00, 001→11, 010→11, 011→01
  - 100→10, 101→00, 110→00, 111→11
- Input acceptance:
  - On a rising edge with rst=0 and in_valid=1: register d, bout and out_valid=1.
  - On a rising edge with rst=0 and in_valid=0: d and bout hold their previous values; out_valid=0.
- No back-pressure; every valid input is accepted. Inputs with in_valid=0 are ignored entirely, including X values.

## Timing
- Latency: 1 clock. Inputs sampled at edge N appear on d, bout and out_valid after edge N. They are stable for the whole cycle N→N+1.
- Throughput: one operation per clock; back-to-back in_valid is fully supported.
- Reset values, applied at the first rising edge with rst=1: d = 0, bout = 0, out_valid = 0.
- Reset has priority over in_valid in the same cycle; that input is discarded.
- Reset asserted mid-stream:
  - Any result captured on that edge is lost.
  - Outputs return to their reset values and remain there while rst stays high.
- Deassertion: the first edge with rst=0 and in_valid=1 produces out_valid=1 on the next cycle.
- Before the first reset, output values are undefined. The bench must apply reset for at least 1 cycle.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset check:
  - Hold rst=1 for 2 cycles with a=1, b=0, bin=0, in_valid=1 → d=0, bout=0, out_valid=0 throughout.
  - Release rst; after one cycle, d=1, bout=0, out_valid=1.
- Exhaustive single-bit check (WIDTH=1):
  - Drive all 8 {a,b,bin} combinations back-to-back with in_valid=1, in counting order with bin as the LSB.
  - Each result appears one cycle later and matches the truth table: d sequence 0,1,1,0,1,0,0,1; bout sequence 0,1,1,1,0,0,0,1.
- Hold behaviour:
  - Apply a=0, b=1, bin=0 valid, then 3 cycles of in_valid=0 with random a/b/bin.
  - Required: d=1, bout=1 are held, and out_valid pulses for exactly one cycle.
- Multi-bit, WIDTH=8:
  - a=8'h05, b=8'h03, bin=1 → d=8'h01, bout=0.
  - a=8'h00, b=8'h00, bin=1 → d=8'hFF, bout=1.
  - a=8'h10, b=8'h20, bin=0 → d=8'hF0, bout=1.
- Reset mid-stream:
  - Assert rst on the same edge as a valid a=1, b=0, bin=0.
  - Required: out_valid stays 0, d=0, and the result is never emitted.
- Random regression, WIDTH=8:
  - Apply 1000 random valid/invalid cycles.
  - Scoreboard {bout, d} against (a − b − bin) mod 512, delayed by 1 cycle; out_valid count must equal the in_valid count.

Source files
------------

// File: rtl/full_subtractor.sv
// Registered full subtractor: {bout, d} = a - b - bin (unsigned), one-cycle latency.
// The difference is built from a ripple-borrow chain of single-bit cells.

// One bit of the borrow chain: difference bit and borrow to the next bit.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ c;
  assign bo = (~a & b) | (~(a ^ b) & c);
endmodule

module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             out_valid
);

  // c[i] is the borrow into bit i; c[WIDTH] leaves the MSB
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] diff;

  assign c[0] = bin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      full_subtractor_cell u_cell (
        .a  (a[i]),
        .b  (b[i]),
        .c  (c[i]),
        .d  (diff[i]),
        .bo (c[i+1])
      );
    end
  endgenerate

  // Capture result only on valid input; reset wins over a same-cycle input.
  // Invalid cycles leave d/bout untouched so X on idle inputs never propagates.
  always_ff @(posedge clk) begin
    if (rst) begin
      d         <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d    <= diff;
        bout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor: one WIDTH=1 and one WIDTH=8 instance.
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0, v1 = 1'b0;
  logic [0:0] d1;
  logic       bo1, ov1;

  logic [7:0] a8 = '0, b8 = '0, d8;
  logic       bin8 = 1'b0, v8 = 1'b0, bo8, ov8;

  int total = 0;
  int bad   = 0;
  int in1 = 0, out1 = 0, in8 = 0, out8 = 0;

  logic [1:0] q1[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .bin(bin1), .in_valid(v1),
    .d(d1), .bout(bo1), .out_valid(ov1)
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .bin(bin8), .in_valid(v8),
    .d(d8), .bout(bo8), .out_valid(ov8)
  );

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor for the 1-bit instance: pop expected on every out_valid
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      out1++;
      if (q1.size() == 0) chk("w1_unexpected_out", {8'd0, bo1, d1}, 10'h3FF);
      else chk("w1_result", {8'd0, bo1, d1}, {8'd0, q1.pop_front()});
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      out8++;
      if (q8.size() == 0) chk("w8_unexpected_out", {1'b0, bo8, d8}, 10'h3FF);
      else chk("w8_result", {1'b0, bo8, d8}, {1'b0, q8.pop_front()});
    end
  end

  // Apply inputs for one cycle; expected result queued only if it will be accepted
  task automatic drive1(input logic a, input logic b, input logic bi, input logic v, input logic [1:0] exp);
    a1 = a; b1 = b; bin1 = bi; v1 = v;
    if (v && !rst) begin q1.push_back(exp); in1++; end
    @(posedge clk); #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic v, input logic [8:0] exp);
    a8 = a; b8 = b; bin8 = bi; v8 = v;
    if (v && !rst) begin q8.push_back(exp); in8++; end
    @(posedge clk); #1;
  endtask

  logic [7:0] dseq = 8'b0110_1001;  // index 7..0 -> combos 0..7 read MSB first
  logic [7:0] bseq = 8'b0111_0001;

  initial begin
    // Reset held two cycles with a valid 1-0-0 on the inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0; v1 = 1'b1;
      a8 = 8'd1; b8 = 8'd0; bin8 = 1'b0; v8 = 1'b1;
      @(posedge clk); #1;
      chk("rst_w1", {7'd0, ov1, bo1, d1}, 10'd0);
      chk("rst_w8", {ov8, bo8, d8}, 10'd0);
    end
    rst = 1'b0;
    in1++; q1.push_back(2'b01);
    in8++; q8.push_back(9'h001);
    @(posedge clk); #1;
    chk("rel_w1", {7'd0, ov1, bo1, d1}, 10'b101);
    chk("rel_w8", {ov8, bo8, d8}, {1'b1, 1'b0, 8'h01});
    v1 = 1'b0; v8 = 1'b0;

    // Exhaustive single-bit truth table, back-to-back
    for (int k = 0; k < 8; k++) begin
      logic [2:0] abc;
      abc = 3'(k);
      drive1(abc[2], abc[1], abc[0], 1'b1, {bseq[7-k], dseq[7-k]});
    end

    // Hold: one valid 0-1-0 then three idle cycles with random inputs
    drive1(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    chk("hold_first", {7'd0, ov1, bo1, d1}, 10'b111);
    for (int k = 0; k < 3; k++) begin
      drive1(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 2'b00);
      chk("hold_idle", {7'd0, ov1, bo1, d1}, 10'b011);
    end

    // Multi-bit directed vectors
    drive8(8'h05, 8'h03, 1'b1, 1'b1, {1'b0, 8'h01});
    drive8(8'h00, 8'h00, 1'b1, 1'b1, {1'b1, 8'hFF});
    drive8(8'h10, 8'h20, 1'b0, 1'b1, {1'b1, 8'hF0});
    drive8(8'hFF, 8'h00, 1'b0, 1'b1, {1'b0, 8'hFF});
    drive8(8'h00, 8'hFF, 1'b1, 1'b1, {1'b1, 8'h00});
    drive8(8'h80, 8'h7F, 1'b1, 1'b1, {1'b0, 8'h00});
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 9'h0);

    // Reset on the same edge as a valid input: result must never appear
    rst = 1'b1;
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    chk("midrst_w1", {7'd0, ov1, bo1, d1}, 10'd0);
    chk("midrst_w8", {ov8, bo8, d8}, 10'd0);
    rst = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("midrst_after", {7'd0, ov1, bo1, d1}, 10'd0);

    // Random regression on the 8-bit instance
    for (int k = 0; k < 1000; k++) begin
      logic [7:0] ra, rb;
      logic       rbi, rv;
      logic [8:0] e;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      rv  = ($urandom_range(0, 3) != 0);
      e   = 9'(({1'b0, ra} - {1'b0, rb} - {8'd0, rbi}) % 512);
      drive8(ra, rb, rbi, rv, e);
    end
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 9'h0);
    @(posedge clk); #1;

    chk("w1_count", 10'(out1), 10'(in1));
    chk("w8_count", 10'(out8), 10'(in8));
    chk("w1_drained", 10'(q1.size()), 10'd0);
    chk("w8_drained", 10'(q8.size()), 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
